// File: rtl/axi_lite_cmd_master_pkg.sv
// rtl/axi_lite_cmd_master_pkg.sv - FSM states, AXI response codes and command record for axi_lite_cmd_master
package axi_lite_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Sized for the widest supported bus; narrower instances zero-extend on push.
    typedef struct packed {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } cmd_t;

endpackage

// File: rtl/lcl_cmd_fifo.sv
// rtl/lcl_cmd_fifo.sv - synchronous command FIFO with registered occupancy count
module lcl_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - queued in-order AXI4-Lite master; LCL_AXI_TIMEOUT_EN adds response timeout
module axi_lite_cmd_master
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lcl_req_valid,
    output logic                lcl_req_ready,
    input  logic                lcl_req_wr,
    input  logic [ADDR_W-1:0]   lcl_req_addr,
    input  logic [DATA_W-1:0]   lcl_req_data,
    input  logic [DATA_W/8-1:0] lcl_req_strb,
    output logic                lcl_rsp_valid,
    output logic                lcl_rsp_wr,
    output logic [1:0]          lcl_rsp_resp,
    output logic                lcl_rsp_timeout,
    output logic [DATA_W-1:0]   lcl_rsp_data,
    output logic                lcl_idle,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    if ((DATA_W != 32 && DATA_W != 64) || ADDR_W > 64 || CMD_DEPTH < 2 ||
        (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("axi_lite_cmd_master: unsupported parameter set");
    end

    state_e state;
    cmd_t   push_cmd;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   head_blocked;
    logic   stale_b;
    logic   stale_r;
    logic   unused_head;

    assign push_cmd.wr   = lcl_req_wr;
    assign push_cmd.addr = 64'(lcl_req_addr);
    assign push_cmd.data = 64'(lcl_req_data);
    assign push_cmd.strb = 8'(lcl_req_strb);

    assign lcl_req_ready = !fifo_full && !rst;
    assign push          = lcl_req_valid && lcl_req_ready;
    // A command waits while a late response of its own kind is still owed by the slave.
    assign head_blocked  = head.wr ? stale_b : stale_r;
    assign pop           = (state == ST_IDLE) && !fifo_empty && !head_blocked;
    assign lcl_idle      = fifo_empty && (state == ST_IDLE) && !stale_b && !stale_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign unused_head   = ^head;

    lcl_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef LCL_AXI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign lcl_rsp_timeout = 1'b0;
    assign stale_b         = 1'b0;
    assign stale_r         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_araddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            lcl_rsp_valid <= 1'b0;
            lcl_rsp_wr    <= 1'b0;
            lcl_rsp_resp  <= AXI_RESP_OKAY;
            lcl_rsp_data  <= '0;
`ifdef LCL_AXI_TIMEOUT_EN
            lcl_rsp_timeout <= 1'b0;
            tmo_cnt         <= '0;
            stale_b         <= 1'b0;
            stale_r         <= 1'b0;
`endif
        end else begin
            lcl_rsp_valid <= 1'b0;
`ifdef LCL_AXI_TIMEOUT_EN
            // Late responses to timed-out commands are accepted and dropped.
            if (stale_b) begin
                m_axi_bready <= !(m_axi_bvalid && m_axi_bready);
                if (m_axi_bvalid && m_axi_bready) stale_b <= 1'b0;
            end
            if (stale_r) begin
                m_axi_rready <= !(m_axi_rvalid && m_axi_rready);
                if (m_axi_rvalid && m_axi_rready) stale_r <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head.wr) begin
                            m_axi_awaddr  <= head.addr[ADDR_W-1:0];
                            m_axi_wdata   <= head.data[DATA_W-1:0];
                            m_axi_wstrb   <= head.strb[DATA_W/8-1:0];
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            m_axi_araddr  <= head.addr[ADDR_W-1:0];
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
`ifdef LCL_AXI_TIMEOUT_EN
                        tmo_cnt      <= '0;
`endif
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready  <= 1'b0;
                        lcl_rsp_valid <= 1'b1;
                        lcl_rsp_wr    <= 1'b1;
                        lcl_rsp_resp  <= m_axi_bresp;
                        lcl_rsp_data  <= '0;
`ifdef LCL_AXI_TIMEOUT_EN
                        lcl_rsp_timeout <= 1'b0;
`endif
                        state         <= ST_IDLE;
                    end
`ifdef LCL_AXI_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        m_axi_bready    <= 1'b0;
                        lcl_rsp_valid   <= 1'b1;
                        lcl_rsp_wr      <= 1'b1;
                        lcl_rsp_resp    <= AXI_RESP_SLVERR;
                        lcl_rsp_data    <= '0;
                        lcl_rsp_timeout <= 1'b1;
                        stale_b         <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_RESP;
`ifdef LCL_AXI_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                ST_RD_RESP: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        m_axi_rready  <= 1'b0;
                        lcl_rsp_valid <= 1'b1;
                        lcl_rsp_wr    <= 1'b0;
                        lcl_rsp_resp  <= m_axi_rresp;
                        lcl_rsp_data  <= m_axi_rdata;
`ifdef LCL_AXI_TIMEOUT_EN
                        lcl_rsp_timeout <= 1'b0;
`endif
                        state         <= ST_IDLE;
                    end
`ifdef LCL_AXI_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        m_axi_rready    <= 1'b0;
                        lcl_rsp_valid   <= 1'b1;
                        lcl_rsp_wr      <= 1'b0;
                        lcl_rsp_resp    <= AXI_RESP_SLVERR;
                        lcl_rsp_data    <= '0;
                        lcl_rsp_timeout <= 1'b1;
                        stale_r         <= 1'b1;
                        state           <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - directed self-checking bench for axi_lite_cmd_master
module tb_axi_lite_cmd_master;

    typedef struct packed {
        logic        wr;
        logic        to;
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        lcl_req_valid, lcl_req_ready, lcl_req_wr;
    logic [31:0] lcl_req_addr, lcl_req_data;
    logic [3:0]  lcl_req_strb;
    logic        lcl_rsp_valid, lcl_rsp_wr, lcl_rsp_timeout, lcl_idle;
    logic [1:0]  lcl_rsp_resp;
    logic [31:0] lcl_rsp_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    logic        auto_slave;
    logic        man_bvalid, man_rvalid;
    logic [1:0]  man_bresp, man_rresp;
    logic [31:0] man_rdata;
    logic [31:0] last_ar;
    rsp_t        rsp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          base;

    axi_lite_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .lcl_req_valid(lcl_req_valid), .lcl_req_ready(lcl_req_ready), .lcl_req_wr(lcl_req_wr),
        .lcl_req_addr(lcl_req_addr), .lcl_req_data(lcl_req_data), .lcl_req_strb(lcl_req_strb),
        .lcl_rsp_valid(lcl_rsp_valid), .lcl_rsp_wr(lcl_rsp_wr), .lcl_rsp_resp(lcl_rsp_resp),
        .lcl_rsp_timeout(lcl_rsp_timeout), .lcl_rsp_data(lcl_rsp_data), .lcl_idle(lcl_idle),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave responses change on the falling edge; auto mode answers every ready at once.
    always @(negedge clk) begin
        if (auto_slave) begin
            m_axi_bvalid <= m_axi_bready;
            m_axi_bresp  <= 2'b00;
            m_axi_rvalid <= m_axi_rready;
            m_axi_rdata  <= 32'hC0DE0000 ^ last_ar;
            m_axi_rresp  <= 2'b00;
        end else begin
            m_axi_bvalid <= man_bvalid;
            m_axi_bresp  <= man_bresp;
            m_axi_rvalid <= man_rvalid;
            m_axi_rdata  <= man_rdata;
            m_axi_rresp  <= man_rresp;
        end
    end

    always @(posedge clk) begin
        if (m_axi_arvalid && m_axi_arready) last_ar <= m_axi_araddr;
    end

    always @(negedge clk) begin
        if (lcl_rsp_valid) rsp_q.push_back({lcl_rsp_wr, lcl_rsp_timeout, lcl_rsp_resp, lcl_rsp_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        logic done;
        done          = 1'b0;
        lcl_req_valid = 1'b1;
        lcl_req_wr    = wr;
        lcl_req_addr  = addr;
        lcl_req_data  = data;
        lcl_req_strb  = strb;
        for (int i = 0; i < 60 && !done; i++) begin
            if (lcl_req_ready) done = 1'b1;
            tick();
        end
        lcl_req_valid = 1'b0;
        check("push_accept", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        lcl_req_valid = 1'b0; lcl_req_wr = 1'b0; lcl_req_addr = '0; lcl_req_data = '0; lcl_req_strb = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        auto_slave = 1'b0; man_bvalid = 1'b0; man_rvalid = 1'b0;
        man_bresp = 2'b00; man_rresp = 2'b00; man_rdata = '0; last_ar = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", lcl_req_ready, 0);
        check("rst_idle", lcl_idle, 1);
        check("rst_handshakes", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, lcl_rsp_valid}, 0);
        check("rst_awaddr", m_axi_awaddr, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", lcl_req_ready, 1);
        tick();

        // Write, zero-wait slave: valids in cycle 2, response pulse in cycle 4.
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        push_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("t1_c1_awvalid", m_axi_awvalid, 0);
        tick();
        check("t1_c2_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b110);
        check("t1_awaddr", m_axi_awaddr, 32'h10);
        check("t1_wdata", m_axi_wdata, 32'hDEADBEEF);
        check("t1_wstrb", m_axi_wstrb, 4'hF);
        tick();
        check("t1_c3_bready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
        man_bresp = 2'b00; man_bvalid = 1'b1;
        tick();
        man_bvalid = 1'b0;
        check("t1_rsp", {lcl_rsp_valid, lcl_rsp_wr, lcl_rsp_resp, lcl_rsp_timeout}, 5'b11000);
        check("t1_rsp_data", lcl_rsp_data, 0);
        check("t1_bready_drop", m_axi_bready, 0);
        tick();
        check("t1_pulse_end", lcl_rsp_valid, 0);
        check("t1_idle", lcl_idle, 1);

        // Read with three wait cycles and SLVERR passed through.
        push_cmd(1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        check("t2_arvalid", {m_axi_arvalid, m_axi_rready}, 2'b10);
        check("t2_araddr", m_axi_araddr, 32'h20);
        tick();
        check("t2_rready", {m_axi_arvalid, m_axi_rready}, 2'b01);
        repeat (3) tick();
        check("t2_no_early_rsp", lcl_rsp_valid, 0);
        man_rdata = 32'h12345678; man_rresp = 2'b10; man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        check("t2_rsp", {lcl_rsp_valid, lcl_rsp_wr, lcl_rsp_resp, lcl_rsp_timeout}, 5'b10100);
        check("t2_rsp_data", lcl_rsp_data, 32'h12345678);
        check("t2_rready_drop", m_axi_rready, 0);
        tick();
        check("t2_idle", lcl_idle, 1);

        // W accepted five cycles before AW: each valid drops on its own handshake.
        m_axi_awready = 1'b0; m_axi_wready = 1'b1;
        base = rsp_q.size();
        push_cmd(1'b1, 32'h30, 32'hA5A5A5A5, 4'h3);
        tick();
        check("t3_c2_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        tick();
        check("t3_w_dropped", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
        check("t3_awaddr_hold", m_axi_awaddr, 32'h30);
        repeat (3) tick();
        check("t3_aw_held", {m_axi_awvalid, m_axi_bready}, 2'b10);
        tick();
        m_axi_awready = 1'b1;
        tick();
        check("t3_aw_done", {m_axi_awvalid, m_axi_bready}, 2'b01);
        man_bresp = 2'b11; man_bvalid = 1'b1;
        tick();
        man_bvalid = 1'b0;
        check("t3_rsp", {lcl_rsp_valid, lcl_rsp_wr, lcl_rsp_resp}, 4'b1111);
        repeat (3) tick();
        check("t3_rsp_count", rsp_q.size() - base, 1);

        // Six commands against stalled slave: one sits in the FSM, four fill the FIFO.
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        base = rsp_q.size();
        for (int i = 0; i < 5; i++)
            push_cmd(i[0] == 1'b0, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
        lcl_req_valid = 1'b1;
        check("t4_full_ready", lcl_req_ready, 0);
        tick();
        check("t4_full_hold", lcl_req_ready, 0);
        lcl_req_valid = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        auto_slave = 1'b1;
        push_cmd(1'b0, 32'h114, 32'h1005, 4'hF);
        for (int k = 0; k < 300 && (rsp_q.size() - base) < 6; k++) tick();
        check("t4_rsp_count", rsp_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < rsp_q.size()) begin
                check("t4_rsp_wr", rsp_q[base + i].wr, (i % 2) == 0);
                check("t4_rsp_data", rsp_q[base + i].data,
                      (i % 2 == 0) ? 32'h0 : (32'hC0DE0000 ^ (32'h100 + 32'(4 * i))));
            end
        end
        repeat (2) tick();
        check("t4_idle", lcl_idle, 1);

`ifdef LCL_AXI_TIMEOUT_EN
        // Withheld BVALID: timeout response, late B drained without a second response.
        auto_slave = 1'b0; man_bvalid = 1'b0;
        base = rsp_q.size();
        push_cmd(1'b1, 32'h40, 32'h55, 4'hF);
        for (int k = 0; k < 60 && rsp_q.size() == base; k++) tick();
        check("t5_rsp_count", rsp_q.size() - base, 1);
        if (rsp_q.size() > base) begin
            check("t5_timeout", {rsp_q[base].wr, rsp_q[base].to, rsp_q[base].resp}, 4'b1110);
            check("t5_data", rsp_q[base].data, 0);
        end
        check("t5_stale_bready", m_axi_bready, 1);
        check("t5_not_idle", lcl_idle, 0);
        man_bresp = 2'b00; man_bvalid = 1'b1;
        tick();
        man_bvalid = 1'b0;
        repeat (3) tick();
        check("t5_no_extra", rsp_q.size() - base, 1);
        check("t5_idle", lcl_idle, 1);
        auto_slave = 1'b1;
        push_cmd(1'b1, 32'h44, 32'h66, 4'hF);
        for (int k = 0; k < 60 && rsp_q.size() < base + 2; k++) tick();
        check("t5_next_count", rsp_q.size() - base, 2);
        if (rsp_q.size() > base + 1)
            check("t5_next_rsp", {rsp_q[base + 1].to, rsp_q[base + 1].resp}, 3'b000);
`endif

        // Reset while in WR_RESP with three commands queued.
        auto_slave = 1'b0; man_bvalid = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        base = rsp_q.size();
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 4'hF);
        check("t6_in_wr_resp", {m_axi_bready, lcl_idle, lcl_req_ready}, 3'b101);
        rst = 1'b1;
        #1;
        check("t6_rst_handshakes", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, lcl_rsp_valid}, 0);
        check("t6_rst_ready", lcl_req_ready, 0);
        check("t6_rst_idle", lcl_idle, 1);
        check("t6_rst_awaddr", m_axi_awaddr, 0);
        check("t6_rst_wdata", {m_axi_wdata, m_axi_wstrb}, 0);
        check("t6_rst_rsp", {lcl_rsp_wr, lcl_rsp_resp, lcl_rsp_data}, 0);
        tick();
        rst = 1'b0;
        auto_slave = 1'b1;
        repeat (6) tick();
        check("t6_no_rsp", rsp_q.size() - base, 0);
        check("t6_after", {lcl_idle, m_axi_awvalid, lcl_req_ready}, 3'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
